tlp_tx_arbiter: RTL
===================

# tlp_tx_arbiter

Packet-atomic round-robin arbiter that shares the single PCIe AXI4-Stream TX interface (s_axis_tx_*) between two 64-bit TLP sources: port 0 (PIO completer, completions) and port 1 (NUMA requester, memory read/write requests). It sits between those engines and the PCIe core in the user_clk (250 MHz) domain. It adds one registered output stage and sequences the cfg_to_turnoff / cfg_turnoff_ok power-down handshake.

## Interface
- No parameters; data width fixed at 64, keep width at 8, counter width at 16.
- user_clk  in  1  TX clock, 250 MHz; all logic on rising edge
- sys_rst_n  in  1  synchronous reset, active-low
- user_lnk_up  in  1  link up; no new grant while low
- in0_tdata / in1_tdata  in  64  source TLP beat
- in0_tkeep / in1_tkeep  in  8  byte enables
- in0_tlast / in1_tlast  in  1  last beat of TLP
- in0_tvalid / in1_tvalid  in  1  beat valid
- in0_tready / in1_tready  out  1  beat accepted when tvalid && tready
- s_axis_tx_tdata  out  64  to PCIe core
- s_axis_tx_tkeep  out  8
- s_axis_tx_tlast  out  1
- s_axis_tx_tvalid  out  1
- s_axis_tx_tready  in  1  core ready
- tx_src_dsc  out  1  constant 0
- cfg_to_turnoff  in  1  core requests turnoff
- cfg_turnoff_ok  out  1  safe to turn off
- pkt_cnt0 / pkt_cnt1  out  16  TLPs forwarded per port, wrapping

## Operation
- States: IDLE, GRANT0, GRANT1.
- IDLE: no in*_tready. If user_lnk_up && !cfg_to_turnoff and at least one in*_tvalid, pick the winner and move to GRANTk next cycle.
- Winner selection: if only one port is valid, that port wins. If both are valid, the port named by the priority pointer rr wins. After a grant to port k, rr = ~k. Reset value of rr is 0.
- GRANTk: in_k_tready = !out_valid || s_axis_tx_tready. The other port's tready is 0. Each accepted beat loads the output register.
- GRANTk -> IDLE on the cycle a beat with in_k_tlast is accepted. pkt_cnt_k increments (mod 2^16) on that same edge.
- Packets are never interleaved. user_lnk_up or cfg_to_turnoff rising mid-packet does not abort the packet; it only blocks the next grant.
- Output register: out_valid set on accept. Cleared when s_axis_tx_tready && !accept. Held (data stable) while tvalid && !tready.
- Turnoff: cfg_turnoff_ok is a register. It is set when cfg_to_turnoff && state==IDLE && !out_valid. It is cleared the cycle after cfg_to_turnoff goes low. While cfg_to_turnoff is high, no grants are made.

## Timing
- Reset values: all in*_tready 0, s_axis_tx_tvalid 0, s_axis_tx_tdata/tkeep/tlast 0, cfg_turnoff_ok 0, pkt_cnt0/1 0, state IDLE, rr 0.
- Arbitration latency: tvalid seen in IDLE at cycle N gives GRANT at N+1. The first beat is accepted at N+1 and appears on s_axis_tx at N+2.
- Throughput: 1 beat/cycle within a packet while s_axis_tx_tready is held high. One idle cycle between packets (the IDLE state).
- Backpressure: when s_axis_tx_tready is low with out_valid high, in_k_tready drops in the same cycle. This is combinational from s_axis_tx_tready, and no beat is lost or duplicated.
- Single-beat TLP (tlast on the first beat): GRANTk lasts 1 cycle.
- Simultaneous request and turnoff: when cfg_to_turnoff and a tvalid are both high in IDLE, turnoff wins. No grant is made.
- Reset asserted mid-packet: all state returns to reset values on that edge. The partial packet is discarded; upstream engines are reset by the same sys_rst_n.

## Test plan
- Single source: port 0 sends a 3-beat TLP (data 0x...01/02/03, tlast on beat 3) with tready=1 -> beats appear on s_axis_tx at cycles N+2..N+4, tkeep unchanged, pkt_cnt0=1, pkt_cnt1=0.
- Contention: both ports hold 2-beat TLPs continuously for 4 packets -> output order is port 0, 1, 0, 1, with no beat interleaving inside a packet; pkt_cnt0=pkt_cnt1=2.
- Backpressure: port 1 sends a 4-beat TLP while s_axis_tx_tready toggles 1,0,0,1,... -> s_axis_tx_tdata is held stable while stalled, all 4 beats arrive in order exactly once, and in1_tready=0 while stalled.
- Turnoff mid-packet: cfg_to_turnoff rises during beat 2 of a 4-beat port 0 TLP while port 1 is valid -> port 0 packet completes, port 1 is not granted, cfg_turnoff_ok=1 one cycle after the output drains, and cfg_turnoff_ok=0 the cycle after cfg_to_turnoff falls, after which port 1 is granted.
- Link down: user_lnk_up=0 with both ports valid -> no tready for 10 cycles. Raising user_lnk_up -> port 0 is granted first.
- Counter wrap: force pkt_cnt1=16'hFFFF, send one port 1 TLP -> pkt_cnt1=16'h0000.

Source files
------------

// File: rtl/tlp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tlp_tx_arbiter
//
// Shares the single PCIe AXI4-Stream TX interface between two 64-bit TLP
// sources: port 0 (PIO completer) and port 1 (NUMA requester). A packet, once
// granted, owns the output until its tlast beat is accepted. Ties are broken by
// a round-robin pointer. One registered output stage sits in front of the
// core. The block also runs the cfg_to_turnoff / cfg_turnoff_ok handshake.
//
// Ports
//   user_clk, sys_rst_n       clock (250 MHz), synchronous active-low reset
//   user_lnk_up               link up; no new grant while low
//   in{0,1}_t{data,keep,last,valid} / in{0,1}_tready
//                             source TLP streams (64-bit data, 8-bit keep)
//   s_axis_tx_t{data,keep,last,valid} / s_axis_tx_tready
//                             registered stream to the PCIe core
//   tx_src_dsc                tied low (this block never discontinues a TLP)
//   cfg_to_turnoff            core asks for turnoff; blocks new grants
//   cfg_turnoff_ok            registered "nothing in flight" acknowledge
//   pkt_cnt0, pkt_cnt1        wrapping count of TLPs forwarded per port
// -----------------------------------------------------------------------------
module tlp_tx_arbiter (
    input  logic        user_clk,
    input  logic        sys_rst_n,
    input  logic        user_lnk_up,

    input  logic [63:0] in0_tdata,
    input  logic [7:0]  in0_tkeep,
    input  logic        in0_tlast,
    input  logic        in0_tvalid,
    output logic        in0_tready,

    input  logic [63:0] in1_tdata,
    input  logic [7:0]  in1_tkeep,
    input  logic        in1_tlast,
    input  logic        in1_tvalid,
    output logic        in1_tready,

    output logic [63:0] s_axis_tx_tdata,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic        s_axis_tx_tlast,
    output logic        s_axis_tx_tvalid,
    input  logic        s_axis_tx_tready,
    output logic        tx_src_dsc,

    input  logic        cfg_to_turnoff,
    output logic        cfg_turnoff_ok,

    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1
);

    typedef struct packed {
        logic       last;
        logic [7:0] keep;
        logic [63:0] data;
    } beat_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    // Source ports gathered into packed arrays so the datapath is indexed by
    // the granted port number rather than duplicated per port.
    beat_t [1:0] in_beat;
    logic  [1:0] in_valid;
    logic  [1:0] in_ready;
    logic  [1:0] in_acc;

    assign in_beat[0] = {in0_tlast, in0_tkeep, in0_tdata};
    assign in_beat[1] = {in1_tlast, in1_tkeep, in1_tdata};
    assign in_valid   = {in1_tvalid, in0_tvalid};

    // State
    logic [1:0]  state_q,    state_d;
    logic        rr_q,       rr_d;
    logic        out_vld_q,  out_vld_d;
    beat_t       out_beat_q, out_beat_d;
    logic        ok_q,       ok_d;
    logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0] pkt_cnt1_q, pkt_cnt1_d;

    // Datapath helpers
    logic gsel;      // port currently granted (meaningful in GRANTk only)
    logic can_load;  // output register can take a beat this cycle
    logic accept;    // a beat is transferred from the granted source
    logic acc_last;  // ... and it is the last beat of the TLP
    logic win;       // arbitration winner in IDLE

    always_comb begin
        gsel     = (state_q == ST_GRANT1);
        // Ready is combinational from s_axis_tx_tready so a stalled output
        // drops upstream ready in the same cycle without losing a beat.
        can_load = !out_vld_q || s_axis_tx_tready;

        in_ready = 2'b00;
        if (state_q == ST_GRANT0) in_ready[0] = can_load;
        if (state_q == ST_GRANT1) in_ready[1] = can_load;

        in_acc   = in_valid & in_ready;
        accept   = |in_acc;
        acc_last = accept && in_beat[gsel].last;
    end

    // Arbitration FSM
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Turnoff and link-down only gate new grants; a packet in
                // progress always runs to its tlast.
                if (user_lnk_up && !cfg_to_turnoff && (|in_valid)) begin
                    win     = (&in_valid) ? rr_q : in_valid[1];
                    state_d = win ? ST_GRANT1 : ST_GRANT0;
                    rr_d    = ~win;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (acc_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load on accept, drop when the core takes the beat and
    // nothing replaces it, otherwise hold.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_beat_d = out_beat_q;
        if (accept) begin
            out_beat_d = in_beat[gsel];
            out_vld_d  = 1'b1;
        end else if (s_axis_tx_tready) begin
            out_vld_d  = 1'b0;
        end
    end

    // Per-port packet counters, bumped on the tlast accept edge.
    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        if (acc_last && !gsel) pkt_cnt0_d = pkt_cnt0_q + 16'd1;
        if (acc_last &&  gsel) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
    end

    // Turnoff acknowledge: only once the FSM is idle and the output register
    // has drained is nothing left in flight toward the core.
    always_comb begin
        ok_d = ok_q;
        if (!cfg_to_turnoff)
            ok_d = 1'b0;
        else if (state_q == ST_IDLE && !out_vld_q)
            ok_d = 1'b1;
    end

    always_ff @(posedge user_clk) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            rr_q       <= 1'b0;
            out_vld_q  <= 1'b0;
            out_beat_q <= '0;
            ok_q       <= 1'b0;
            pkt_cnt0_q <= 16'd0;
            pkt_cnt1_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            out_vld_q  <= out_vld_d;
            out_beat_q <= out_beat_d;
            ok_q       <= ok_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign in0_tready       = in_ready[0];
    assign in1_tready       = in_ready[1];
    assign s_axis_tx_tdata  = out_beat_q.data;
    assign s_axis_tx_tkeep  = out_beat_q.keep;
    assign s_axis_tx_tlast  = out_beat_q.last;
    assign s_axis_tx_tvalid = out_vld_q;
    assign tx_src_dsc       = 1'b0;
    assign cfg_turnoff_ok   = ok_q;
    assign pkt_cnt0         = pkt_cnt0_q;
    assign pkt_cnt1         = pkt_cnt1_q;

endmodule
